// File: rtl/ser_pkg.sv
// Shared serial-link definitions used by both the transmit scheduler and the receiver controller.
// Optional feature macro: SER_TX_PARITY_EN adds an even-parity helper for the PAR bit.
package ser_pkg;

  localparam int   PORTW     = 2;
  localparam int   LENW      = 4;
  localparam int   DATAW     = 15;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    PORT  = 3'd2,
    LEN   = 3'd3,
    DATA  = 3'd4,
    PAR   = 3'd5,
    DONE  = 3'd6
  } ser_state_t;

`ifdef SER_TX_PARITY_EN
  // Only the len low data bits are on the wire, so only they count toward parity.
  function automatic logic ser_even_parity(input logic [PORTW-1:0] id,
                                           input logic [LENW-1:0]  len,
                                           input logic [DATAW-1:0] data);
    logic [DATAW-1:0] mask;
    mask = (DATAW'(1) << len) - DATAW'(1);
    return ^{id, len, data & mask};
  endfunction
`endif

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or after ptr.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PTRW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PTRW-1:0] ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant
);

  // Scan from ptr, wrapping, and take the first requester found.
  always_comb begin
    logic            found_s;
    logic [PTRW-1:0] idx_s;
    grant   = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = ptr + PTRW'(k);
      if (enable && !found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/ser_tx_scheduler.sv
// Round-robin transmit scheduler: latches one requester's frame and serialises start, id, len, data.
// Optional feature macro: SER_TX_PARITY_EN appends an even-parity bit before the DONE tick.
module ser_tx_scheduler
  import ser_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LENW = 4,
  parameter int DW   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clkEn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*LENW-1:0] len_in,
  input  logic [NREQ*DW-1:0]   data_in,
  output logic [NREQ-1:0]      gnt,
  output logic                 SerOut,
  output logic                 busy,
  output logic                 Done
);

  localparam int PTRW  = $clog2(NREQ);
  localparam int LIDXW = $clog2(LENW);

  ser_state_t         state_r, state_s;
  logic [LENW-1:0]    cnt_r, cnt_s;
  logic [PTRW-1:0]    ptr_r, gidx_s;
  logic [PORTW-1:0]   id_r;
  logic [LENW-1:0]    len_r;
  logic [DW-1:0]      data_r;
  logic               ser_r, ser_s, busy_r, done_r;
  logic [NREQ-1:0]    gnt_s;

  rr_arbiter #(.NREQ(NREQ), .PTRW(PTRW)) u_arb (
    .req    (req),
    .ptr    (ptr_r),
    .enable (clkEn && (state_r == IDLE)),
    .grant  (gnt_s)
  );

  // One-hot grant to requester index.
  always_comb begin
    gidx_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_s[i]) begin
        gidx_s = PTRW'(i);
      end else begin
        gidx_s = gidx_s;
      end
    end
  end

  // Next state, bit counter and the line level that the next state drives.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    ser_s   = LINE_IDLE;
    case (state_r)
      IDLE: begin
        if (gnt_s != '0) begin
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        state_s = PORT;
        cnt_s   = LENW'(PORTW - 1);
      end
      PORT: begin
        if (cnt_r == '0) begin
          state_s = LEN;
          cnt_s   = LENW'(LENW - 1);
        end else begin
          cnt_s = cnt_r - LENW'(1);
        end
      end
      LEN: begin
        if (cnt_r != '0) begin
          cnt_s = cnt_r - LENW'(1);
        end else if (len_r == '0) begin
`ifdef SER_TX_PARITY_EN
          state_s = PAR;
`else
          state_s = DONE;
`endif
        end else begin
          state_s = DATA;
          cnt_s   = len_r - LENW'(1);
        end
      end
      DATA: begin
        if (cnt_r == '0) begin
`ifdef SER_TX_PARITY_EN
          state_s = PAR;
`else
          state_s = DONE;
`endif
        end else begin
          cnt_s = cnt_r - LENW'(1);
        end
      end
`ifdef SER_TX_PARITY_EN
      PAR:     state_s = DONE;
`endif
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase

    case (state_s)
      START:   ser_s = 1'b0;
      PORT:    ser_s = id_r[cnt_s[0]];
      LEN:     ser_s = len_r[cnt_s[LIDXW-1:0]];
      DATA:    ser_s = data_r[cnt_s];
`ifdef SER_TX_PARITY_EN
      PAR:     ser_s = ser_even_parity(id_r, len_r, data_r);
`endif
      default: ser_s = LINE_IDLE;
    endcase
  end

  // State, frame latch and registered line outputs; everything advances on clkEn only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      ptr_r   <= '0;
      id_r    <= '0;
      len_r   <= '0;
      data_r  <= '0;
      ser_r   <= LINE_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (clkEn) begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ser_r   <= ser_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
      if (gnt_s != '0) begin
        id_r   <= PORTW'(gidx_s);
        len_r  <= len_in[int'(gidx_s)*LENW +: LENW];
        data_r <= data_in[int'(gidx_s)*DW +: DW];
        ptr_r  <= gidx_s + PTRW'(1);
      end else begin
        ptr_r <= ptr_r;
      end
    end else begin
      state_r <= state_r;
    end
  end

  assign gnt    = gnt_s;
  assign SerOut = ser_r;
  assign busy   = busy_r;
  assign Done   = done_r;

endmodule

// File: tb/tb_ser_tx_scheduler.sv
// Directed bench for ser_tx_scheduler: framing, zero length, round-robin, clkEn gating, mid-frame reset.
module tb_ser_tx_scheduler;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        clkEn = 1'b1;
  logic [3:0]  req   = 4'b0000;
  logic [15:0] len_in  = 16'h0000;
  logic [59:0] data_in = 60'h0;
  logic [3:0]  gnt;
  logic        SerOut, busy, Done;

  int n_vec = 0;
  int n_err = 0;
  logic gate_mode = 1'b0;
  int   gate_cyc  = 0;

  ser_tx_scheduler dut (
    .clk(clk), .rst(rst), .clkEn(clkEn), .req(req), .len_in(len_in), .data_in(data_in),
    .gnt(gnt), .SerOut(SerOut), .busy(busy), .Done(Done)
  );

  always #5 clk = ~clk;

  // clkEn high every cycle, or one cycle in three when gating
  always @(posedge clk) begin
    #2;
    if (gate_mode) begin
      gate_cyc = (gate_cyc + 1) % 3;
      clkEn    = (gate_cyc == 0);
    end else begin
      clkEn = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_port(input int i, input logic [3:0] l, input logic [14:0] d);
    len_in[i*4 +: 4]   = l;
    data_in[i*15 +: 15] = d;
  endtask

  // Expected line bits, first bit sent at index n-1.
  task automatic frame_bits(input logic [1:0] id, input logic [3:0] len, input logic [14:0] data,
                            output logic [31:0] v, output int n);
    logic p;
    v = '0; n = 0; p = 1'b0;
    v = {v[30:0], 1'b0}; n++;
    for (int k = 1; k >= 0; k--) begin v = {v[30:0], id[k]}; n++; p ^= id[k]; end
    for (int k = 3; k >= 0; k--) begin v = {v[30:0], len[k]}; n++; p ^= len[k]; end
    for (int k = int'(len) - 1; k >= 0; k--) begin v = {v[30:0], data[k]}; n++; p ^= data[k]; end
`ifdef SER_TX_PARITY_EN
    v = {v[30:0], p}; n++;
`endif
  endtask

  // Wait for grant, then check every line bit (held 'hold' clocks) and the Done tick.
  task automatic do_frame(input string tag, input logic [3:0] exp_gnt, input logic [1:0] id,
                          input logic [3:0] len, input logic [14:0] data, input int hold,
                          input bit drop, output int w);
    logic [31:0] v;
    int n;
    w = 0;
    #1;
    while (gnt == 4'b0000 && w < 20) begin
      @(negedge clk); #1; w++;
    end
    check({tag, "_gnt"}, gnt, exp_gnt);
    if (w > 0) begin
      check({tag, "_idle_ser"}, SerOut, 1'b1);
      check({tag, "_idle_done"}, Done, 1'b0);
    end
    frame_bits(id, len, data, v, n);
    for (int b = 0; b < n; b++) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk); #1;
        if (b == 0 && h == 0) begin
          check({tag, "_gnt_pulse"}, gnt, 4'b0000);
          if (drop) req = 4'b0000;
        end
        check($sformatf("%s_bit%0d", tag, b), SerOut, v[n-1-b]);
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_nodone"}, Done, 1'b0);
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      check({tag, "_done"}, Done, 1'b1);
      check({tag, "_done_ser"}, SerOut, 1'b1);
    end
  endtask

  initial begin
    int w;
    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_ser", SerOut, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_gnt", gnt, 4'b0000);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // 1: single frame, requester 0, len 3, data 101
    set_port(0, 4'd3, 15'b101);
    req = 4'b0001;
    do_frame("t1", 4'b0001, 2'd0, 4'd3, 15'b101, 1, 1'b1, w);
    @(negedge clk); #1;
    check("t1_after_busy", busy, 1'b0);
    check("t1_after_done", Done, 1'b0);

    // 2: zero length, requester 2
    @(negedge clk);
    set_port(2, 4'd0, 15'h7FFF);
    req = 4'b0100;
    do_frame("t2", 4'b0100, 2'd2, 4'd0, 15'h0, 1, 1'b1, w);

    // 3: round-robin from a fresh pointer
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    set_port(0, 4'd1, 15'b1);
    set_port(1, 4'd2, 15'b10);
    set_port(2, 4'd3, 15'b011);
    set_port(3, 4'd0, 15'h0);
    @(negedge clk);
    req = 4'b1111;
    do_frame("rr0", 4'b0001, 2'd0, 4'd1, 15'b1,   1, 1'b0, w);
    do_frame("rr1", 4'b0010, 2'd1, 4'd2, 15'b10,  1, 1'b0, w);
    check("rr1_gap", w, 1);
    do_frame("rr2", 4'b0100, 2'd2, 4'd3, 15'b011, 1, 1'b0, w);
    check("rr2_gap", w, 1);
    do_frame("rr3", 4'b1000, 2'd3, 4'd0, 15'h0,   1, 1'b0, w);
    check("rr3_gap", w, 1);
    do_frame("rr4", 4'b0001, 2'd0, 4'd1, 15'b1,   1, 1'b1, w);
    check("rr4_gap", w, 1);

    // 4: clkEn one cycle in three, same frame as case 1
    @(negedge clk);
    set_port(0, 4'd3, 15'b101);
    gate_mode = 1'b1;
    @(negedge clk);
    req = 4'b0001;
    do_frame("t4", 4'b0001, 2'd0, 4'd3, 15'b101, 3, 1'b1, w);
    gate_mode = 1'b0;
    repeat (4) @(negedge clk);

    // 5: reset during DATA of a len 15 frame
    set_port(1, 4'd15, 15'h2AAA);
    req = 4'b0010;
    #1;
    check("t5_gnt", gnt, 4'b0010);
    @(negedge clk); req = 4'b0000;
    repeat (9) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("t5_rst_ser", SerOut, 1'b1);
    check("t5_rst_busy", busy, 1'b0);
    repeat (3) begin
      @(negedge clk); #1;
      check("t5_rst_nodone", Done, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    set_port(0, 4'd2, 15'b10);
    req = 4'b1111;
    do_frame("t5_next", 4'b0001, 2'd0, 4'd2, 15'b10, 1, 1'b1, w);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

endmodule
